// File: rtl/level_flow_fsm_if.sv
// Bundle between the game-flow controller and the rest of the game: frame/start/score/player
// inputs in, flow state and banner/reset controls out.
interface level_flow_fsm_if;
    logic               frame_clk;
    logic               start_key;
    logic [3:0]         score;
    logic signed [15:0] player1_top;
    logic signed [15:0] player1_bottom;
    logic signed [15:0] player1_left;
    logic signed [15:0] player1_right;
    logic signed [15:0] player2_top;
    logic signed [15:0] player2_bottom;
    logic signed [15:0] player2_left;
    logic signed [15:0] player2_right;
    logic               p1_hazard;
    logic               p2_hazard;
    logic [1:0]         game_state;
    logic               freeze;
    logic               banner_on;
    logic               level_reset;
    logic [9:0]         play_seconds;

    modport master (
        output frame_clk, start_key, score,
        output player1_top, player1_bottom, player1_left, player1_right,
        output player2_top, player2_bottom, player2_left, player2_right,
        output p1_hazard, p2_hazard,
        input  game_state, freeze, banner_on, level_reset, play_seconds
    );

    modport slave (
        input  frame_clk, start_key, score,
        input  player1_top, player1_bottom, player1_left, player1_right,
        input  player2_top, player2_bottom, player2_left, player2_right,
        input  p1_hazard, p2_hazard,
        output game_state, freeze, banner_on, level_reset, play_seconds
    );
endinterface

// File: rtl/level_flow_fsm.sv
// Game-flow controller: IDLE/PLAY/WIN/LOSE decisions once per frame tick, banner blink,
// play-time seconds counter and a one-cycle level_reset pulse on every (re)start.
module level_flow_fsm #(
    parameter logic [3:0]         MIN_GEMS     = 4'd2,
    parameter logic [5:0]         DOOR_HOLD    = 6'd30,
    parameter logic [5:0]         BLINK_FRAMES = 6'd15,
    parameter logic [6:0]         FPS          = 7'd60,
    parameter logic signed [15:0] DOOR1_X      = 16'sd560,
    parameter logic signed [15:0] DOOR1_Y      = 16'sd40,
    parameter logic signed [15:0] DOOR2_X      = 16'sd600,
    parameter logic signed [15:0] DOOR2_Y      = 16'sd40,
    parameter logic signed [15:0] DOOR_W       = 16'sd24,
    parameter logic signed [15:0] DOOR_H       = 16'sd32
) (
    input logic              Clk,
    input logic              Reset,
    level_flow_fsm_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WIN  = 2'd2;
    localparam logic [1:0] S_LOSE = 2'd3;

    localparam logic [9:0]         SEC_MAX = 10'd999;
    localparam logic signed [15:0] D1_XR   = DOOR1_X + DOOR_W;
    localparam logic signed [15:0] D1_YB   = DOOR1_Y + DOOR_H;
    localparam logic signed [15:0] D2_XR   = DOOR2_X + DOOR_W;
    localparam logic signed [15:0] D2_YB   = DOOR2_Y + DOOR_H;

    logic       r_fc_s1, r_fc_s2, r_fc_d, r_tick;
    logic       r_sk_s, r_sk_d;
    logic [1:0] r_state;
    logic       r_freeze, r_banner, r_level_reset;
    logic [9:0] r_sec;
    logic [6:0] r_frame;
    logic [5:0] r_hold;
    logic [5:0] r_blink;

    logic w_start, w_in_door1, w_in_door2, w_door_ok;

    // Strict overlap: touching a door edge does not count as standing in it.
    assign w_in_door1 = (bus.player1_right > DOOR1_X) && (bus.player1_left < D1_XR) &&
                        (bus.player1_bottom > DOOR1_Y) && (bus.player1_top < D1_YB);
    assign w_in_door2 = (bus.player2_right > DOOR2_X) && (bus.player2_left < D2_XR) &&
                        (bus.player2_bottom > DOOR2_Y) && (bus.player2_top < D2_YB);
    assign w_door_ok  = w_in_door1 && w_in_door2 && (bus.score >= MIN_GEMS);
    assign w_start    = r_sk_s & ~r_sk_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fc_s1 <= 1'b0;
            r_fc_s2 <= 1'b0;
            r_fc_d  <= 1'b0;
            r_tick  <= 1'b0;
            r_sk_s  <= 1'b0;
            r_sk_d  <= 1'b0;
        end else begin
            r_fc_s1 <= bus.frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_d  <= r_fc_s2;
            r_tick  <= r_fc_s2 & ~r_fc_d;
            r_sk_s  <= bus.start_key;
            r_sk_d  <= r_sk_s;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_freeze      <= 1'b1;
            r_banner      <= 1'b0;
            r_level_reset <= 1'b0;
            r_sec         <= '0;
            r_frame       <= '0;
            r_hold        <= '0;
            r_blink       <= '0;
        end else begin
            r_level_reset <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    if (r_tick) begin
                        if (r_frame == FPS - 7'd1) begin
                            r_frame <= '0;
                            if (r_sec != SEC_MAX) r_sec <= r_sec + 10'd1;
                        end else begin
                            r_frame <= r_frame + 7'd1;
                        end
                        // Death outranks a win decided on the same frame.
                        if (bus.p1_hazard || bus.p2_hazard) begin
                            r_state  <= S_LOSE;
                            r_freeze <= 1'b1;
                            r_banner <= 1'b1;
                            r_blink  <= '0;
                        end else if (w_door_ok) begin
                            r_hold <= r_hold + 6'd1;
                            if (r_hold == DOOR_HOLD - 6'd1) begin
                                r_state  <= S_WIN;
                                r_freeze <= 1'b1;
                                r_banner <= 1'b1;
                                r_blink  <= '0;
                            end
                        end else begin
                            r_hold <= '0;
                        end
                    end
                end
                default: begin
                    if (w_start) begin
                        r_state       <= S_PLAY;
                        r_freeze      <= 1'b0;
                        r_banner      <= 1'b0;
                        r_level_reset <= 1'b1;
                        r_sec         <= '0;
                        r_frame       <= '0;
                        r_hold        <= '0;
                        r_blink       <= '0;
                    end else if (r_tick && (r_state != S_IDLE)) begin
                        if (r_blink == BLINK_FRAMES - 6'd1) begin
                            r_blink  <= '0;
                            r_banner <= ~r_banner;
                        end else begin
                            r_blink <= r_blink + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.game_state   = r_state;
    assign bus.freeze       = r_freeze;
    assign bus.banner_on    = r_banner;
    assign bus.level_reset  = r_level_reset;
    assign bus.play_seconds = r_sec;
endmodule

// File: tb/tb_level_flow_fsm.sv
// Randomised and directed bench for level_flow_fsm against a frame-level reference model.
module tb_level_flow_fsm;
    localparam int FPS_T   = 4;
    localparam int HOLD_T  = 30;
    localparam int BLINK_T = 15;
    localparam int MIN_T   = 2;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    level_flow_fsm_if bus();

    level_flow_fsm #(.FPS(7'(FPS_T))) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int lr_cnt = 0;

    // Reference model: one update per accepted frame or start request
    int m_state, m_hold, m_frame, m_sec, m_blink, m_banner, m_resets;

    always @(posedge Clk) if (bus.level_reset === 1'b1) lr_cnt++;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_frame = 0; m_sec = 0;
        m_blink = 0; m_banner = 0; m_resets = 0;
        lr_cnt = 0;
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".state"},   int'(bus.game_state),   m_state);
        chk({tag, ".freeze"},  int'(bus.freeze),       (m_state == 1) ? 0 : 1);
        chk({tag, ".banner"},  int'(bus.banner_on),    m_banner);
        chk({tag, ".seconds"}, int'(bus.play_seconds), m_sec);
        chk({tag, ".resets"},  lr_cnt,                 m_resets);
    endtask

    function automatic bit in_door(input int t, input int b, input int l, input int r,
                                   input int dx, input int dy);
        return (r > dx) && (l < dx + 24) && (b > dy) && (t < dy + 32);
    endfunction

    // Candidate boxes relative to a door: in, far away, edge-touching, barely in, negative coords
    task automatic box(input int sel, input int dx, output int t, output int b,
                       output int l, output int r);
        t = 45; b = 65; l = dx + 4; r = dx + 14;
        case (sel)
            1: begin t = 300; b = 330; l = 100; r = 120; end
            2: begin l = dx - 10; r = dx; end
            3: begin l = dx + 24; r = dx + 34; end
            4: begin t = 72; b = 90; end
            5: begin l = dx - 10; r = dx + 1; end
            6: begin t = -10; b = 5; l = -20; r = -5; end
            default: ;
        endcase
    endtask

    task automatic do_tick(input bit h1, input bit h2, input int s1, input int s2,
                           input int sc, input string tag);
        int t1, b1, l1, r1, t2, b2, l2, r2;
        bit in1, in2;
        box(s1, 560, t1, b1, l1, r1);
        box(s2, 600, t2, b2, l2, r2);
        in1 = in_door(t1, b1, l1, r1, 560, 40);
        in2 = in_door(t2, b2, l2, r2, 600, 40);
        @(negedge Clk);
        bus.player1_top = 16'(t1); bus.player1_bottom = 16'(b1);
        bus.player1_left = 16'(l1); bus.player1_right = 16'(r1);
        bus.player2_top = 16'(t2); bus.player2_bottom = 16'(b2);
        bus.player2_left = 16'(l2); bus.player2_right = 16'(r2);
        bus.p1_hazard = h1; bus.p2_hazard = h2; bus.score = 4'(sc);
        bus.frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        bus.p1_hazard = 1'b0; bus.p2_hazard = 1'b0;
        if (m_state == 1) begin
            m_frame++;
            if (m_frame == FPS_T) begin
                m_frame = 0;
                if (m_sec < 999) m_sec++;
            end
            if (h1 || h2) begin
                m_state = 3; m_banner = 1; m_blink = 0;
            end else if (in1 && in2 && sc >= MIN_T) begin
                m_hold++;
                if (m_hold == HOLD_T) begin
                    m_state = 2; m_banner = 1; m_blink = 0;
                end
            end else begin
                m_hold = 0;
            end
        end else if (m_state >= 2) begin
            m_blink++;
            if (m_blink == BLINK_T) begin
                m_blink = 0; m_banner = !m_banner;
            end
        end
        cmp_all(tag);
    endtask

    task automatic press_start(input int hold, input string tag);
        @(negedge Clk);
        bus.start_key = 1'b1;
        repeat (hold) @(negedge Clk);
        bus.start_key = 1'b0;
        repeat (3) @(negedge Clk);
        if (m_state != 1) begin
            m_state = 1; m_hold = 0; m_frame = 0; m_sec = 0;
            m_banner = 0; m_blink = 0; m_resets++;
        end
        cmp_all(tag);
    endtask

    int sc_r;

    initial begin
        bus.frame_clk = 1'b0; bus.start_key = 1'b0; bus.score = 4'd0;
        bus.p1_hazard = 1'b0; bus.p2_hazard = 1'b0;
        bus.player1_top = '0; bus.player1_bottom = '0; bus.player1_left = '0; bus.player1_right = '0;
        bus.player2_top = '0; bus.player2_bottom = '0; bus.player2_left = '0; bus.player2_right = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        cmp_all("reset");
        chk("reset.level_reset", int'(bus.level_reset), 0);
        Reset = 1'b1;

        // Idle ignores frames; held start gives one restart pulse
        do_tick(1'b1, 1'b0, 0, 0, 2, "idle_tick");
        press_start(100, "t2_start");
        chk("t2.pulses", lr_cnt, 1);
        for (int i = 0; i < FPS_T; i++) do_tick(1'b0, 1'b0, 1, 1, 0, "t2_time");
        chk("t2.one_second", int'(bus.play_seconds), 1);

        // Asynchronous reset in the middle of play
        while (m_sec < 5) do_tick(1'b0, 1'b0, 1, 0, 3, "t1_run");
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("t1.state",   int'(bus.game_state),   0);
        chk("t1.freeze",  int'(bus.freeze),       1);
        chk("t1.seconds", int'(bus.play_seconds), 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        cmp_all("t1_after");

        // Hold interrupted by one frame out of the door
        press_start(1, "t3_start");
        for (int i = 0; i < 29; i++) do_tick(1'b0, 1'b0, 0, 5, 2, "t3_in_a");
        do_tick(1'b0, 1'b0, 0, 2, 2, "t3_out");
        for (int i = 0; i < 29; i++) do_tick(1'b0, 1'b0, 5, 0, 2, "t3_in_b");
        chk("t3.still_play", int'(bus.game_state), 1);
        do_tick(1'b0, 1'b0, 0, 0, 2, "t3_win");
        chk("t3.win", int'(bus.game_state), 2);

        // Too few gems never wins
        press_start(2, "t4_start");
        for (int i = 0; i < 40; i++) do_tick(1'b0, 1'b0, 0, 0, 1, "t4_low");
        chk("t4.no_win", int'(bus.game_state), 1);
        for (int i = 0; i < 30; i++) do_tick(1'b0, 1'b0, 0, 0, 2, "t4_ok");
        chk("t4.win", int'(bus.game_state), 2);

        // Restart from WIN, then play-time saturation
        press_start(4, "t6_start");
        chk("t6.banner", int'(bus.banner_on), 0);
        for (int i = 0; i < 1000 * FPS_T + 3; i++) do_tick(1'b0, 1'b0, 3, 4, 9, "t6_sat");
        chk("t6.sat999", int'(bus.play_seconds), 999);

        // Hazard on the frame that would have completed the hold
        press_start(1, "t5_start");
        for (int i = 0; i < 29; i++) do_tick(1'b0, 1'b0, 0, 0, 2, "t5_hold");
        do_tick(1'b0, 1'b1, 0, 0, 2, "t5_hazard");
        chk("t5.lose", int'(bus.game_state), 3);
        chk("t5.banner_on", int'(bus.banner_on), 1);
        for (int i = 0; i < 14; i++) do_tick(1'b0, 1'b0, 0, 0, 2, "t5_blink");
        chk("t5.banner_still", int'(bus.banner_on), 1);
        do_tick(1'b0, 1'b0, 0, 0, 2, "t5_toggle");
        chk("t5.banner_off", int'(bus.banner_on), 0);

        // Randomised play
        sc_r = 2;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0 || (m_state != 1 && $urandom_range(0, 24) == 0)) begin
                sc_r = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 15));
                press_start(int'($urandom_range(1, 6)), "rnd_start");
            end else begin
                do_tick($urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0,
                        ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 6)) : 0,
                        ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 6)) : 0,
                        sc_r, "rnd_tick");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
